// File: rtl/cfs_md_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ MD requester ports onto one
// shared MD master port. A grant is held until the transfer completes or
// the granted requester drops valid early. An early drop sets a sticky
// protocol-error flag.
module cfs_md_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 2,
    localparam int unsigned OFFSET_WIDTH = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1,
    localparam int unsigned SIZE_WIDTH   = $clog2(DATA_WIDTH / 8) + 1,
    localparam int unsigned GID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    // requester side
    input  logic [NUM_REQ-1:0]              s_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_data,
    input  logic [NUM_REQ*OFFSET_WIDTH-1:0] s_offset,
    input  logic [NUM_REQ*SIZE_WIDTH-1:0]   s_size,
    output logic [NUM_REQ-1:0]              s_ready,
    output logic [NUM_REQ-1:0]              s_err,
    // shared master side
    output logic                            m_valid,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic [OFFSET_WIDTH-1:0]         m_offset,
    output logic [SIZE_WIDTH-1:0]           m_size,
    input  logic                            m_ready,
    input  logic                            m_err,
    // status
    output logic [GID_WIDTH-1:0]            grant_id,
    output logic                            busy,
    output logic                            proto_err
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e               state_q, state_d;
    logic [GID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic [GID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic                 proto_err_q, proto_err_d;
    logic [GID_WIDTH-1:0] winner;

    // Round-robin search starting one past the last completed grant.
    always_comb begin
        logic found;
        int   idx;
        found  = 1'b0;
        winner = last_grant_q;
        idx    = 0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx = (int'(last_grant_q) + k) % int'(NUM_REQ);
            if (!found && s_valid[idx[GID_WIDTH-1:0]]) begin
                found  = 1'b1;
                winner = idx[GID_WIDTH-1:0];
            end
        end
    end

    // Next-state logic: grant on any request, release on completion or early drop.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        proto_err_d  = proto_err_q;
        unique case (state_q)
            StIdle: begin
                if (|s_valid) begin
                    grant_id_d = winner;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (s_valid[grant_id_q] && m_ready) begin
                    last_grant_d = grant_id_q;
                    state_d      = StIdle;
                end else if (!s_valid[grant_id_q]) begin
                    // Valid withdrawn without a handshake: abandon the grant.
                    proto_err_d  = 1'b1;
                    last_grant_d = grant_id_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset leaves last_grant at the top so requester 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            grant_id_q   <= '0;
            last_grant_q <= GID_WIDTH'(NUM_REQ - 1);
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Output mux: the granted requester is connected straight through while in GRANT.
    always_comb begin
        m_valid  = 1'b0;
        s_ready  = '0;
        s_err    = '0;
        m_data   = s_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        m_offset = s_offset[grant_id_q*OFFSET_WIDTH +: OFFSET_WIDTH];
        m_size   = s_size[grant_id_q*SIZE_WIDTH +: SIZE_WIDTH];
        if (state_q == StGrant) begin
            m_valid             = s_valid[grant_id_q];
            s_ready[grant_id_q] = m_ready;
            s_err[grant_id_q]   = m_err & m_ready;
        end
    end

    assign grant_id  = grant_id_q;
    assign busy      = (state_q == StGrant);
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cfs_md_arbiter.sv
// Bench for cfs_md_arbiter (4 requesters, 32-bit data): directed scenarios
// followed by random traffic, all checked against a transaction-level model.
module tb_cfs_md_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int OW = 2;
    localparam int SW = 3;
    localparam int GW = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NR-1:0]    s_valid;
    logic [NR*DW-1:0] s_data;
    logic [NR*OW-1:0] s_offset;
    logic [NR*SW-1:0] s_size;
    logic [NR-1:0]    s_ready;
    logic [NR-1:0]    s_err;
    logic             m_valid;
    logic [DW-1:0]    m_data;
    logic [OW-1:0]    m_offset;
    logic [SW-1:0]    m_size;
    logic             m_ready;
    logic             m_err;
    logic [GW-1:0]    grant_id;
    logic             busy;
    logic             proto_err;

    cfs_md_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_offset (s_offset),
        .s_size   (s_size),
        .s_ready  (s_ready),
        .s_err    (s_err),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_offset (m_offset),
        .m_size   (m_size),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .grant_id (grant_id),
        .busy     (busy),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who holds the grant, who was served last, sticky error.
    bit mdl_grant;
    int mdl_gid;
    int mdl_last;
    bit mdl_perr;
    int hs_id;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        mdl_grant = 1'b0;
        mdl_gid   = 0;
        mdl_last  = NR - 1;
        mdl_perr  = 1'b0;
    endtask

    task automatic check_outputs();
        logic [NR-1:0] er;
        logic [NR-1:0] ee;
        logic          ev;
        er = '0;
        ee = '0;
        ev = 1'b0;
        if (mdl_grant) begin
            ev          = s_valid[mdl_gid];
            er[mdl_gid] = m_ready;
            ee[mdl_gid] = m_ready & m_err;
        end
        chk("m_valid", 64'(m_valid), 64'(ev));
        chk("busy", 64'(busy), 64'(mdl_grant));
        chk("grant_id", 64'(grant_id), 64'(mdl_gid));
        chk("proto_err", 64'(proto_err), 64'(mdl_perr));
        chk("s_ready", 64'(s_ready), 64'(er));
        chk("s_err", 64'(s_err), 64'(ee));
        if (mdl_grant) begin
            chk("m_data", 64'(m_data), 64'(s_data[mdl_gid*DW +: DW]));
            chk("m_offset", 64'(m_offset), 64'(s_offset[mdl_gid*OW +: OW]));
            chk("m_size", 64'(m_size), 64'(s_size[mdl_gid*SW +: SW]));
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        hs_id = -1;
        if (!mdl_grant) begin
            if (s_valid != '0) begin
                bit found;
                found = 1'b0;
                for (int k = 1; k <= NR; k++) begin
                    int i;
                    i = (mdl_last + k) % NR;
                    if (!found && s_valid[i]) begin
                        found   = 1'b1;
                        mdl_gid = i;
                    end
                end
                mdl_grant = 1'b1;
            end
        end else if (s_valid[mdl_gid] && m_ready) begin
            hs_id     = mdl_gid;
            mdl_last  = mdl_gid;
            mdl_grant = 1'b0;
        end else if (!s_valid[mdl_gid]) begin
            mdl_perr  = 1'b1;
            mdl_last  = mdl_gid;
            mdl_grant = 1'b0;
        end
    endtask

    // Inputs are driven at the falling edge; check, then let one rising edge pass.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mdl_reset();
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_proto_err", 64'(proto_err), 64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_s_err", 64'(s_err), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int gl_id[$];
        int gl_cyc[$];
        int exp_order[5];
        bit prev_busy;

        reset_n = 1'b0;
        s_valid = '0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        for (int i = 0; i < NR; i++) begin
            s_data[i*DW +: DW]   = $urandom;
            s_offset[i*OW +: OW] = OW'($urandom);
            s_size[i*SW +: SW]   = SW'($urandom_range(0, 4));
        end

        // Two requesters pending through reset; requester 0 wins first.
        s_valid = 4'b0011;
        m_ready = 1'b1;
        do_reset();
        m_ready = 1'b0;
        cycle();
        chk("first_gid", 64'(grant_id), 64'(0));
        chk("first_m_valid", 64'(m_valid), 64'(1));
        chk("first_m_data", 64'(m_data), 64'(s_data[0 +: DW]));
        cycle();
        m_ready = 1'b1;
        cycle();
        s_valid[0] = 1'b0;
        m_ready    = 1'b0;
        cycle();
        chk("second_gid", 64'(grant_id), 64'(1));
        chk("second_busy", 64'(busy), 64'(1));

        // Requester 1 stalled for five cycles, then completes with an error.
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("stall_s_ready", 64'(s_ready), 64'(0));
        end
        m_ready = 1'b1;
        m_err   = 1'b1;
        #1;
        chk("err_s_ready", 64'(s_ready), 64'(4'b0010));
        chk("err_s_err", 64'(s_err), 64'(4'b0010));
        cycle();
        s_valid = '0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        cycle();

        // All four requesting continuously: strict rotation, two cycles per transfer.
        do_reset();
        s_valid   = 4'b1111;
        m_ready   = 1'b1;
        prev_busy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (busy && !prev_busy) begin
                gl_id.push_back(int'(grant_id));
                gl_cyc.push_back(c);
            end
            prev_busy = busy;
        end
        exp_order = '{0, 1, 2, 3, 0};
        chk("rr_count", 64'(gl_id.size()), 64'(5));
        for (int k = 0; k < gl_id.size() && k < 5; k++) begin
            chk("rr_order", 64'(gl_id[k]), 64'(exp_order[k]));
            if (k > 0) chk("rr_spacing", 64'(gl_cyc[k] - gl_cyc[k-1]), 64'(2));
        end

        // Granted requester withdraws valid before ready.
        s_valid = '0;
        m_ready = 1'b0;
        do_reset();
        s_valid = 4'b0001;
        cycle();
        cycle();
        s_valid = '0;
        cycle();
        chk("perr_set", 64'(proto_err), 64'(1));
        chk("perr_idle", 64'(busy), 64'(0));

        // Completion signals while idle are ignored; sticky error remains.
        m_ready = 1'b1;
        m_err   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("idle_s_ready", 64'(s_ready), 64'(0));
            chk("idle_s_err", 64'(s_err), 64'(0));
            chk("perr_sticky", 64'(proto_err), 64'(1));
        end

        // Reset while a grant is outstanding clears outputs before any edge.
        m_ready = 1'b0;
        m_err   = 1'b0;
        s_valid = 4'b0100;
        s_size[2*SW +: SW] = 3'd4;
        cycle();
        cycle();
        chk("mid_m_size", 64'(m_size), 64'(4));
        chk("mid_m_valid", 64'(m_valid), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_m_valid", 64'(m_valid), 64'(0));
        chk("async_busy", 64'(busy), 64'(0));
        chk("async_grant_id", 64'(grant_id), 64'(0));
        chk("async_proto_err", 64'(proto_err), 64'(0));
        mdl_reset();
        @(negedge clk);
        s_valid = '0;
        reset_n = 1'b1;

        // Random traffic: requests stay pending until served.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!s_valid[i] && $urandom_range(0, 2) == 0) begin
                    s_valid[i]           = 1'b1;
                    s_data[i*DW +: DW]   = $urandom;
                    s_offset[i*OW +: OW] = OW'($urandom);
                    s_size[i*SW +: SW]   = SW'($urandom_range(0, 4));
                end
            end
            m_ready = ($urandom_range(0, 2) == 0);
            m_err   = 1'($urandom);
            cycle();
            if (hs_id >= 0) s_valid[hs_id] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
